// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus a four-state qualification FSM that turns a bouncing
// asynchronous level into a clean level with one-cycle rise/fall strobes.
module input_debouncer #(
    parameter int STABLE_COUNT = 50000,
    parameter int CNT_WIDTH    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);
    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

    logic                 r_s1, r_s2;
    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic                 r_dout, r_rise, r_fall, r_busy;
    logic                 w_rise_nxt, w_fall_nxt;
    logic                 w_dout_nxt, w_busy_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            IDLE_LOW: begin
                if (r_s2) begin
                    w_state_nxt = WAIT_HIGH;
                    w_cnt_nxt   = CNT_WIDTH'(1);
                end
            end
            WAIT_HIGH: begin
                // Any return to the current level discards all accumulated credit.
                if (!r_s2) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            IDLE_HIGH: begin
                if (!r_s2) begin
                    w_state_nxt = WAIT_LOW;
                    w_cnt_nxt   = CNT_WIDTH'(1);
                end
            end
            WAIT_LOW: begin
                if (r_s2) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
        w_dout_nxt = (w_state_nxt == IDLE_HIGH) || (w_state_nxt == WAIT_LOW);
        w_busy_nxt = (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
            r_dout  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_s1    <= din;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dout  <= w_dout_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = r_busy;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed test-plan scenarios plus randomized bouncing input, checked against a
// run-length reference model of the debouncer.
module tb_input_debouncer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dout, rise, fall, busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: delay line for the synchronizer, run length of samples
    // that disagree with the current output level.
    bit m_s1, m_s2, m_dout, m_rise, m_fall;
    int m_run;

    input_debouncer #(.STABLE_COUNT(N), .CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .din (din),
        .dout(dout),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit d, input bit r);
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_dout = 0; m_rise = 0; m_fall = 0; m_run = 0;
        end else begin
            m_rise = 0;
            m_fall = 0;
            if (m_s2 == m_dout) m_run = 0;
            else                m_run++;
            if (m_run == N) begin
                m_dout = ~m_dout;
                m_rise = m_dout;
                m_fall = ~m_dout;
                m_run  = 0;
            end
            m_s2 = m_s1;
            m_s1 = d;
        end
    endtask

    // One clock: drive, clock, update the model, sample 1 time unit after the edge.
    task automatic step(input bit d, input bit r);
        din = d;
        rst = r;
        @(posedge clk);
        model_edge(d, r);
        #1;
        chk("dout", {31'd0, dout}, {31'd0, m_dout});
        chk("rise", {31'd0, rise}, {31'd0, m_rise});
        chk("fall", {31'd0, fall}, {31'd0, m_fall});
        chk("busy", {31'd0, busy}, {31'd0, m_run != 0});
        chk("excl", {31'd0, rise & fall}, 32'd0);
    endtask

    int rise_cnt, rise_at, hold;
    bit cur;

    initial begin
        // 1: reset held with din high
        for (int i = 0; i < 3; i++) begin
            step(1, 1);
            chk("rst_out", {28'd0, dout, rise, fall, busy}, 32'd0);
        end
        for (int i = 0; i < 4; i++) step(0, 0);

        // 2: clean rise
        for (int j = 0; j < 8; j++) begin
            step(1, 0);
            chk("s2_busy", {31'd0, busy}, {31'd0, (j >= 2 && j <= 4)});
            chk("s2_dout", {31'd0, dout}, {31'd0, (j >= 5)});
            chk("s2_rise", {31'd0, rise}, {31'd0, (j == 5)});
            chk("s2_fall", {31'd0, fall}, 32'd0);
        end

        // 5: clean fall from IDLE_HIGH
        for (int j = 0; j < 8; j++) begin
            step(0, 0);
            chk("s5_dout", {31'd0, dout}, {31'd0, (j < 5)});
            chk("s5_fall", {31'd0, fall}, {31'd0, (j == 5)});
            chk("s5_rise", {31'd0, rise}, 32'd0);
        end

        // 3: pulse one cycle too short
        for (int j = 0; j < 11; j++) begin
            step(j < 3, 0);
            chk("s3_dout", {31'd0, dout}, 32'd0);
            chk("s3_rise", {31'd0, rise}, 32'd0);
        end
        chk("s3_busy_end", {31'd0, busy}, 32'd0);

        // 4: bounce 1,0,1,1,0,1 then held high; last 0->1 sample is step 5
        rise_cnt = 0;
        rise_at  = -1;
        for (int j = 0; j < 16; j++) begin
            step((j == 1 || j == 4) ? 1'b0 : 1'b1, 0);
            if (rise) begin rise_cnt++; rise_at = j; end
        end
        chk("s4_rise_cnt", rise_cnt, 32'd1);
        chk("s4_rise_at", rise_at, 32'd10);
        chk("s4_dout", {31'd0, dout}, 32'd1);

        for (int j = 0; j < 8; j++) step(0, 0);
        chk("pre6_dout", {31'd0, dout}, 32'd0);

        // 6: reset mid-qualification, then re-qualify after release
        for (int j = 0; j < 4; j++) step(1, 0);
        chk("s6_busy_pre", {31'd0, busy}, 32'd1);
        step(1, 1);
        chk("s6_rst", {29'd0, dout, busy, rise}, 32'd0);
        rise_at = -1;
        for (int j = 0; j < 8; j++) begin
            step(1, 0);
            if (rise) rise_at = j;
        end
        chk("s6_rise_at", rise_at, 32'd5);
        chk("s6_dout", {31'd0, dout}, 32'd1);

        // Random bouncing runs with occasional reset
        cur = 1'b0;
        for (int k = 0; k < 600; k++) begin
            cur  = ~cur;
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(N, N + 6)
                                               : $urandom_range(1, N);
            for (int h = 0; h < hold; h++)
                step(cur, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/input_debouncer.md
# input_debouncer

Synchronizes and debounces a raw asynchronous level input (push-button or switch) into a clean, single-clock-domain level. The output drives the `A` input of the `not_gate` inverter stage directly downstream. One-cycle rise/fall strobes are also provided for edge-driven logic. Glitches shorter than a programmable stable time never reach the output.

## Interface

Parameters:
- `STABLE_COUNT`, default 50000: consecutive synchronized samples of a new level required before `dout` changes. Legal range is ≥2 and ≤2^CNT_WIDTH−1.
- `CNT_WIDTH`, default 16: width of the internal stability counter.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: reset, synchronous and active-high.
- `din`  input  1: raw input, asynchronous to `clk`, may bounce.
- `dout`  output  1: debounced level; feeds `not_gate.A`.
- `rise`  output  1: one-cycle strobe, high in the same cycle `dout` goes 0→1.
- `fall`  output  1: one-cycle strobe, high in the same cycle `dout` goes 1→0.
- `busy`  output  1: high while a candidate level change is being qualified (WAIT_HIGH/WAIT_LOW).

## Operation

- Two-flop synchronizer: `s1 <= din`, `s2 <= s1`. Only `s2` is used downstream. No combinational path from `din` to any output.
- FSM states:
  - IDLE_LOW: `dout`=0.
  - WAIT_HIGH: `dout`=0, `busy`=1.
  - IDLE_HIGH: `dout`=1.
  - WAIT_LOW: `dout`=1, `busy`=1.
- Transitions, evaluated each edge on `s2`:
  - IDLE_LOW, `s2`=1 → WAIT_HIGH, `cnt`←1.
  - WAIT_HIGH, `s2`=0 → IDLE_LOW, `cnt`←0. This is the glitch-rejection path.
  - WAIT_HIGH, `s2`=1, `cnt`<STABLE_COUNT−1 → stay, `cnt`←`cnt`+1.
  - WAIT_HIGH, `s2`=1, `cnt`=STABLE_COUNT−1 → IDLE_HIGH, `cnt`←0, `dout`←1, `rise`←1.
  - IDLE_HIGH / WAIT_LOW: mirror image with `s2`=0 as the candidate level. The final transition sets `dout`←0 and `fall`←1.
- All outputs are registered. `rise`/`fall` are cleared on every edge where they are not being set, so each is exactly one cycle wide. `rise` and `fall` are never high together.
- Counter never exceeds STABLE_COUNT−1, so there is no wrap-around. `cnt` is zero in both IDLE states.
- Any return of `s2` to the current `dout` level during WAIT restarts qualification from zero on the next change. There is no partial credit.

## Timing

- Reset, when `rst`=1 at an edge:
  - `s1`, `s2`, `cnt` = 0; state = IDLE_LOW.
  - `dout` = 0, `rise` = 0, `fall` = 0, `busy` = 0.
  - Reset overrides every transition, including mid-WAIT and in the cycle a strobe would fire.
- Latency:
  - Edge 0 is the first rising edge that samples a new stable `din`, with N = STABLE_COUNT.
  - `s2` reflects the new level after edge 1.
  - `busy` goes high after edge 2.
  - `dout`, `rise`/`fall` update at edge N+1.
  - `busy` goes low at edge N+1.
  - `rise`/`fall` go low at edge N+2.
- Minimum accepted pulse is N consecutive `s2` samples. Pulses of ≤N−1 cycles at `din` produce no output change and no strobe.
- Reset release with `din` held high: the first edge after release is edge 0, so `dout` rises at edge N+1 with `rise` asserted.

## Test plan

All scenarios use STABLE_COUNT=4, CNT_WIDTH=4.

1. `rst`=1 for 3 edges with `din`=1 → `dout`=0, `rise`=0, `fall`=0, `busy`=0 throughout reset.
2. From IDLE_LOW, `din` 0→1 and held → `busy`=1 after edges 2–4; `dout`=1 and `rise`=1 after edge 5; `rise`=0 after edge 6; `fall` stays 0.
3. `din` high for exactly 3 cycles then low → `dout` stays 0, `rise` never asserts, `busy` returns to 0.
4. Bounce pattern `din`=1,0,1,1,0,1 (one cycle each), then held 1 → `dout` rises exactly 5 edges after the last 0→1 sample, with a single `rise` pulse.
5. From IDLE_HIGH, `din` 1→0 held → `dout`=0 and `fall`=1 after edge 5; `fall` is one cycle wide; `rise`=0 throughout.
6. `rst` pulsed for one edge while `busy`=1 (after edge 3 of a rise) → next cycle `dout`=0, `busy`=0, no `rise`. With `din` still 1, `dout` then rises 5 edges after reset release.
